// File: rtl/seg7_scan_driver_if.sv
// Bus bundle between a display client and the 7-segment scan driver.
// Latency: none (wires only).
// Backpressure: none; LOAD is accepted every cycle, BUSY is advisory.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    // Client -> driver: frame data and live display modes
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic                hex_mode;
    logic                lz_blank;

    // Driver -> board pins / client status
    logic [6:0]          seg;
    logic                dp_out;
    logic [DIGITS-1:0]   an;
    logic                busy;

    modport master (
        output value, dp, load, hex_mode, lz_blank,
        input  seg, dp_out, an, busy
    );

    modport slave (
        input  value, dp, load, hex_mode, lz_blank,
        output seg, dp_out, an, busy
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered frame data.
// Latency: pin outputs lag the scan index by 1 cycle; loaded data appears after the next frame wrap.
// Backpressure: none; LOAD always accepted, last load before a wrap wins, BUSY flags undisplayed data.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    seg7_scan_driver_if.slave  io_bus
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    logic [PW-1:0]        r_presc;
    logic [IW-1:0]        r_idx;
    logic [4*DIGITS-1:0]  r_disp_val;
    logic [DIGITS-1:0]    r_disp_dp;
    logic [4*DIGITS-1:0]  r_pend_val;
    logic [DIGITS-1:0]    r_pend_dp;
    logic                 r_pend_vld;
    logic [6:0]           r_seg;
    logic                 r_dp_out;
    logic [DIGITS-1:0]    r_an;

    logic                 w_tick;
    logic                 w_wrap;
    logic [3:0]           w_code;
    logic                 w_dp_sel;
    logic [DIGITS-1:0]    w_an_nxt;
    logic [DIGITS-1:0]    w_allz;
    logic                 w_run;
    logic                 w_blank;
    logic [6:0]           w_seg_nxt;

    // Segment pattern for one code; codes 10-15 show letters in hex mode, a dash otherwise
    function automatic logic [6:0] f_decode(input logic [3:0] code, input logic hex);
        logic [6:0] pat;
        case (code)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = hex ? 7'h77 : 7'h40;
            4'hB: pat = hex ? 7'h7C : 7'h40;
            4'hC: pat = hex ? 7'h39 : 7'h40;
            4'hD: pat = hex ? 7'h5E : 7'h40;
            4'hE: pat = hex ? 7'h79 : 7'h40;
            default: pat = hex ? 7'h71 : 7'h40;
        endcase
        return pat;
    endfunction

    assign w_tick = (r_presc == PRESC_MAX);
    assign w_wrap = w_tick && (r_idx == IDX_MAX);

    // Dwell prescaler; each tick moves the scan to the next digit, wrapping after the last
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Double buffer: display only changes at a frame wrap, so a frame never mixes old and new data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
        end else if (w_wrap) begin
            // A load landing on the wrap itself bypasses the pending slot
            if (io_bus.load) begin
                r_disp_val <= io_bus.value;
                r_disp_dp  <= io_bus.dp;
            end else if (r_pend_vld) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
            end
            r_pend_vld <= 1'b0;
        end else if (io_bus.load) begin
            r_pend_val <= io_bus.value;
            r_pend_dp  <= io_bus.dp;
            r_pend_vld <= 1'b1;
        end
    end

    // Select the active digit and work out leading-zero blanking from the display buffer
    always_comb begin
        w_code   = '0;
        w_dp_sel = 1'b0;
        w_an_nxt = '1;
        w_allz   = '0;
        w_run    = 1'b1;
        w_blank  = 1'b0;
        // w_allz[i]: codes i..DIGITS-1 are all zero
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_run     = w_run && (r_disp_val[4*i +: 4] == 4'h0);
            w_allz[i] = w_run;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_code      = r_disp_val[4*i +: 4];
                w_dp_sel    = r_disp_dp[i];
                w_an_nxt[i] = 1'b0;
                w_blank     = io_bus.lz_blank && (i != 0) && w_allz[i];
            end
        end
    end

    // Final segment pattern; the decimal point is not affected by blanking
    always_comb begin
        w_seg_nxt = w_blank ? 7'h00 : f_decode(w_code, io_bus.hex_mode);
    end

    // Registered pin drivers so the board sees glitch-free segment and anode lines
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg    <= 7'h00;
            r_dp_out <= 1'b0;
            r_an     <= '1;
        end else begin
            r_seg    <= w_seg_nxt;
            r_dp_out <= w_dp_sel;
            r_an     <= w_an_nxt;
        end
    end

    assign io_bus.seg    = r_seg;
    assign io_bus.dp_out = r_dp_out;
    assign io_bus.an     = r_an;
    assign io_bus.busy   = r_pend_vld;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=4, PRESCALE=4 (16-cycle frames).
// Stimulus pushes the expected pin state for each cycle; a negedge monitor pops and compares.
// Every frame's digit patterns are hand-derived from the decode table.
module tb_seg7_scan_driver;

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       busy;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic exp_busy;
    logic mon_ok;
    exp_t sbq[$];
    exp_t e_mon;

    seg7_scan_driver_if #(.DIGITS(4)) bus ();

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs are sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e_mon = sbq.pop_front();
            n_checks++;
            $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", e_mon.tag, e_mon.cyc, cyc);
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e_mon = sbq.pop_front();
            n_checks++;
            mon_ok = 1'b1;
            if (bus.seg !== e_mon.seg)
                mon_ok = 1'b0;
            if (bus.dp_out !== e_mon.dp)
                mon_ok = 1'b0;
            if (bus.an !== e_mon.an)
                mon_ok = 1'b0;
            if (bus.busy !== e_mon.busy)
                mon_ok = 1'b0;
            if (mon_ok) begin
                n_pass++;
            end else begin
                $display("FAIL %s cyc=%0d: got seg=%h dp=%b an=%b busy=%b, want seg=%h dp=%b an=%b busy=%b",
                         e_mon.tag, cyc, bus.seg, bus.dp_out, bus.an, bus.busy,
                         e_mon.seg, e_mon.dp, e_mon.an, e_mon.busy);
            end
        end
    end

    // Expected pin state after the next rising edge
    task automatic push_exp(input logic [6:0] s, input logic d, input logic [3:0] a,
                            input logic b, input string tag);
        exp_t e;
        e.cyc  = cyc + 1;
        e.seg  = s;
        e.dp   = d;
        e.an   = a;
        e.busy = b;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 16-cycle frame; s0..s3/dpe are what the display buffer should show for digits 0..3.
    // la/lb: cycle indices of LOAD pulses (-1 = none); rj: cycle at which RST is pulsed (-1 = none).
    task automatic run_frame(input string name,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpe, input logic hx, input logic lz,
                             input int la, input logic [15:0] va, input logic [3:0] da,
                             input int lb, input logic [15:0] vb, input logic [3:0] db,
                             input int rj);
        logic [6:0] segs [4];
        segs = '{s0, s1, s2, s3};
        bus.hex_mode = hx;
        bus.lz_blank = lz;
        for (int j = 0; j < 16; j++) begin
            bus.load = 1'b0;
            rst      = 1'b0;
            if (j == la) begin
                bus.value = va;
                bus.dp    = da;
                bus.load  = 1'b1;
            end
            if (j == lb) begin
                bus.value = vb;
                bus.dp    = db;
                bus.load  = 1'b1;
            end
            if (j == rj) begin
                rst      = 1'b1;
                exp_busy = 1'b0;
                push_exp(7'h00, 1'b0, 4'hF, 1'b0, $sformatf("%s j%0d rst", name, j));
                step();
                rst      = 1'b0;
                bus.load = 1'b0;
                return;
            end
            if (j == 15)
                exp_busy = 1'b0;
            else if (bus.load)
                exp_busy = 1'b1;
            push_exp(segs[j/4], dpe[j/4], ~(4'b0001 << (j/4)), exp_busy,
                     $sformatf("%s j%0d", name, j));
            step();
        end
        bus.load = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.value    = '0;
        bus.dp       = '0;
        bus.load     = 1'b0;
        bus.hex_mode = 1'b0;
        bus.lz_blank = 1'b0;
        exp_busy     = 1'b0;

        push_exp(7'h00, 1'b0, 4'hF, 1'b0, "reset0");
        step();
        push_exp(7'h00, 1'b0, 4'hF, 1'b0, "reset1");
        step();
        rst = 1'b0;

        // Zeroed display; load 1234 mid-frame, must not appear until the next frame
        run_frame("F0_zero",  7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 1'b0, 1'b0,
                  5, 16'h1234, 4'b0000, -1, 16'h0, 4'b0, -1);
        run_frame("F1_1234",  7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 1'b0, 1'b0,
                  3, 16'hABCD, 4'b0000, -1, 16'h0, 4'b0, -1);
        run_frame("F2_hex",   7'h5E, 7'h39, 7'h7C, 7'h77, 4'b0000, 1'b1, 1'b0,
                  -1, 16'h0, 4'b0, -1, 16'h0, 4'b0, -1);
        run_frame("F3_bcd",   7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 1'b0, 1'b0,
                  7, 16'h0050, 4'b1000, -1, 16'h0, 4'b0, -1);
        run_frame("F4_lzb",   7'h3F, 7'h6D, 7'h00, 7'h00, 4'b1000, 1'b0, 1'b1,
                  2, 16'h0000, 4'b0000, -1, 16'h0, 4'b0, -1);
        // All-zero with blanking; two loads before the wrap, the second must win
        run_frame("F5_lz0",   7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, 1'b0, 1'b1,
                  3, 16'h1111, 4'b0000, 9, 16'h2222, 4'b0000, -1);
        // Load exactly on the wrap cycle: BUSY stays low, value shows next frame
        run_frame("F6_2222",  7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000, 1'b0, 1'b0,
                  15, 16'h9876, 4'b0101, -1, 16'h0, 4'b0, -1);
        // Pending load then reset at idx=2 while BUSY=1
        run_frame("F7_9876",  7'h7D, 7'h07, 7'h7F, 7'h6F, 4'b0101, 1'b0, 1'b0,
                  2, 16'h5555, 4'b0000, -1, 16'h0, 4'b0, 9);
        run_frame("F8_post",  7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 1'b0, 1'b0,
                  -1, 16'h0, 4'b0, -1, 16'h0, 4'b0, -1);
        run_frame("F9_postlz", 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, 1'b0, 1'b1,
                  -1, 16'h0, 4'b0, -1, 16'h0, 4'b0, -1);

        step();
        step();
        while (sbq.size() > 0) begin
            e_mon = sbq.pop_front();
            n_checks++;
            $display("FAIL %s: expectation left unchecked at end (cycle %0d)", e_mon.tag, e_mon.cyc);
        end
        if (n_pass != n_checks)
            $display("FAIL summary: %0d of %0d checks failed", n_checks - n_pass, n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
